joy_cursor_accel: RTL
=====================

// Module: joy_cursor_accel
// PURPOSE
//  Next-generation joystick cursor updater. Converts two ADC joystick axes into a bounded (x,y) cursor position.
//  - Parametrised coordinate/ADC widths, thresholds, step sizes and bounds.
//  - Detects the cursor-rate tick edge internally; no pre-registered copy is needed at the port.
//  - Adds hold-to-accelerate and exact clamping at the bounds.
//  - Sits between the joystick SPI/ADC front end and the VGA sprite/overlay renderer.
// PARAMETERS
//  CW         10   coordinate width (dot_x/dot_y)
//  AW         10   joystick sample width (joy_x/joy_y, unsigned)
//  LO_FAR     150  sample < LO_FAR  -> far deflection, low side
//  LO_NEAR    400  sample < LO_NEAR -> near deflection, low side
//  HI_NEAR    600  sample > HI_NEAR -> near deflection, high side
//  HI_FAR     850  sample > HI_FAR  -> far deflection, high side
//  STEP_NEAR  10   pixels per tick, near deflection
//  STEP_FAR   20   pixels per tick, far deflection
//  HOLD_TICKS 4    consecutive deflected ticks before boost (1..255)
//  INV_X      1    1: low joy_x moves +x; 0: low joy_x moves -x
//  INV_Y      0    1: low joy_y moves +y; 0: low joy_y moves -y
//  INIT_X     300  reset x;  INIT_Y 271  reset y (must lie within bounds)
//  X_LB 239, X_UB 362, Y_LB 116, Y_UB 426   inclusive position bounds
// PORTS
//  clk      in   1   system clock
//  clr      in   1   asynchronous active-high reset
//  soft_rst in   1   synchronous re-init (game restart); same targets as clr
//  tick     in   1   cursor-rate clock/strobe, any duty; its rising edge is the move event
//  joy_x    in   AW  X-axis sample
//  joy_y    in   AW  Y-axis sample
//  dot_x    out  CW  cursor x, registered
//  dot_y    out  CW  cursor y, registered
//  moving   out  1   1 when the last event had a deflection on either axis
//  fast     out  1   1 while FSM is in BOOST
// BEHAVIOUR
//  - Reset (clr async, or soft_rst sync; soft_rst has priority over a same-cycle event):
//    - dot_x=INIT_X, dot_y=INIT_Y, moving=0, fast=0.
//    - FSM=IDLE, hold counter=0.
//    - tick_q=1, so a tick already high at reset release is not an edge.
//  - Event: ev = tick & ~tick_q, where tick_q is tick delayed one clk. Outputs change only on the clk after ev.
//  - Per axis, each event, direction/magnitude decode with strict compares (first match wins):
//    - < LO_FAR: far low.  < LO_NEAR: near low.  > HI_FAR: far high.  > HI_NEAR: near high.
//    - else centred, step 0.
//    - Low side means + if INV_<axis>=1, otherwise -. High side is the opposite sign.
//  - Step = STEP_NEAR or STEP_FAR, shifted left 1 when FSM==BOOST at the event. X and Y are independent.
//  - FSM: IDLE -> SLOW -> BOOST.
//    - Any event with both axes centred: go to IDLE, cnt=0, moving=0.
//    - Deflected event: moving=1, cnt=min(cnt+1,HOLD_TICKS); enter SLOW, or BOOST when new cnt==HOLD_TICKS.
//    - BOOST stays while deflected. The boost decision uses the pre-event state, so event HOLD_TICKS+1 is the first boosted one.
//    - fast=1 iff state==BOOST.
//  - Arithmetic: compute pos+/-step in CW+2-bit signed; no unsigned wrap at 0 or 2^CW.
//  - Saturate: result > UB -> UB; < LB -> LB. The cursor always lands exactly on a bound, never short of or past it.
//  - No events between ticks: joy inputs may change at any time and are sampled only on the ev cycle.
// CONFIGURATION
//  JOY_CURSOR_WRAP_EN
//    - Defined: the playfield is toroidal. result > UB -> LB; result < LB -> UB. No saturation.
//    - Undefined (default): saturating clamp as above.
// TESTING
//  1. Pulse clr with tick=1 -> dot=(300,271), moving=0, fast=0. Release: no move until tick falls and rises.
//  2. joy_x=100, joy_y=512, one tick edge -> dot_x=320, dot_y=271, moving=1. Tick held high 50 clk -> no further change.
//  3. joy_y=700 for 6 edges -> dot_y 281,291,301,311,331,351. fast=1 after 4th edge. joy_y=512 + edge -> IDLE, fast=0, dot_y=351.
//  4. dot_x=355, joy_x=100 -> dot_x=362; edge again -> 362. With JOY_CURSOR_WRAP_EN: 355 -> 239.
//  5. joy_x=900, joy_y=100 from reset -> dot=(280,251) in one event; at dot_y=120, next -> 116.
//  6. soft_rst asserted on the ev cycle -> dot=(300,271), FSM IDLE. clr mid-BOOST -> immediate init, fast=0.

Source files
------------

// File: rtl/joy_cursor_accel.sv
// Joystick cursor: tick rising edge moves (dot_x,dot_y) one step, 1 clk after the edge; no backpressure.
// Hold-to-boost doubles the step; bounds saturate, or wrap when JOY_CURSOR_WRAP_EN is defined.
module joy_cursor_accel #(
  parameter int CW         = 10,
  parameter int AW         = 10,
  parameter int LO_FAR     = 150,
  parameter int LO_NEAR    = 400,
  parameter int HI_NEAR    = 600,
  parameter int HI_FAR     = 850,
  parameter int STEP_NEAR  = 10,
  parameter int STEP_FAR   = 20,
  parameter int HOLD_TICKS = 4,
  parameter int INV_X      = 1,
  parameter int INV_Y      = 0,
  parameter int INIT_X     = 300,
  parameter int INIT_Y     = 271,
  parameter int X_LB       = 239,
  parameter int X_UB       = 362,
  parameter int Y_LB       = 116,
  parameter int Y_UB       = 426
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          soft_rst,
  input  logic          tick,
  input  logic [AW-1:0] joy_x,
  input  logic [AW-1:0] joy_y,
  output logic [CW-1:0] dot_x,
  output logic [CW-1:0] dot_y,
  output logic          moving,
  output logic          fast
);

  localparam int PW = CW + 2;
  typedef logic signed [PW-1:0] pos_t;
  typedef enum logic [1:0] {IDLE, SLOW, BOOST} state_t;

  localparam logic [AW-1:0] LO_FAR_A  = AW'(LO_FAR);
  localparam logic [AW-1:0] LO_NEAR_A = AW'(LO_NEAR);
  localparam logic [AW-1:0] HI_NEAR_A = AW'(HI_NEAR);
  localparam logic [AW-1:0] HI_FAR_A  = AW'(HI_FAR);
  localparam logic [PW-1:0] STEP_N    = PW'(STEP_NEAR);
  localparam logic [PW-1:0] STEP_F    = PW'(STEP_FAR);
  localparam logic [7:0]    HOLD_C    = 8'(HOLD_TICKS);
  localparam logic          INV_X_B   = (INV_X != 0);
  localparam logic          INV_Y_B   = (INV_Y != 0);
  localparam logic [CW-1:0] INIT_XC   = CW'(INIT_X);
  localparam logic [CW-1:0] INIT_YC   = CW'(INIT_Y);
  localparam pos_t          X_LB_S    = pos_t'(X_LB);
  localparam pos_t          X_UB_S    = pos_t'(X_UB);
  localparam pos_t          Y_LB_S    = pos_t'(Y_LB);
  localparam pos_t          Y_UB_S    = pos_t'(Y_UB);

  state_t        state;
  logic [7:0]    cnt;
  logic [7:0]    cnt_inc;
  logic          tick_q;
  logic          ev;
  logic          x_defl;
  logic          y_defl;
  pos_t          x_step;
  pos_t          y_step;
  logic [CW-1:0] x_next;
  logic [CW-1:0] y_next;

  function automatic logic deflected(input logic [AW-1:0] s);
    return (s < LO_FAR_A) || (s < LO_NEAR_A) || (s > HI_FAR_A) || (s > HI_NEAR_A);
  endfunction

  // Low side moves + when inverted, - otherwise; high side is the opposite sign.
  function automatic pos_t axis_step(input logic [AW-1:0] s, input logic inv, input logic boost);
    logic [PW-1:0] mag;
    logic          low;
    mag = '0;
    low = 1'b0;
    if (s < LO_FAR_A) begin
      mag = STEP_F;
      low = 1'b1;
    end else if (s < LO_NEAR_A) begin
      mag = STEP_N;
      low = 1'b1;
    end else if (s > HI_FAR_A) begin
      mag = STEP_F;
    end else if (s > HI_NEAR_A) begin
      mag = STEP_N;
    end
    if (boost) mag = mag << 1;
    return (low == inv) ? $signed(mag) : -$signed(mag);
  endfunction

  function automatic logic [CW-1:0] land(input pos_t v, input pos_t lb, input pos_t ub);
    logic [CW-1:0] r;
    r = v[CW-1:0];
`ifdef JOY_CURSOR_WRAP_EN
    if (v > ub)      r = lb[CW-1:0];
    else if (v < lb) r = ub[CW-1:0];
`else
    if (v > ub)      r = ub[CW-1:0];
    else if (v < lb) r = lb[CW-1:0];
`endif
    return r;
  endfunction

  always_comb begin
    ev      = tick & ~tick_q;
    x_defl  = deflected(joy_x);
    y_defl  = deflected(joy_y);
    x_step  = axis_step(joy_x, INV_X_B, state == BOOST);
    y_step  = axis_step(joy_y, INV_Y_B, state == BOOST);
    x_next  = land($signed({2'b00, dot_x}) + x_step, X_LB_S, X_UB_S);
    y_next  = land($signed({2'b00, dot_y}) + y_step, Y_LB_S, Y_UB_S);
    cnt_inc = (cnt >= HOLD_C) ? HOLD_C : cnt + 8'd1;
  end

  // tick_q resets high so a tick already high at reset release is not an edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      tick_q <= 1'b1;
      dot_x  <= INIT_XC;
      dot_y  <= INIT_YC;
      moving <= 1'b0;
      fast   <= 1'b0;
      state  <= IDLE;
      cnt    <= '0;
    end else if (soft_rst) begin
      tick_q <= 1'b1;
      dot_x  <= INIT_XC;
      dot_y  <= INIT_YC;
      moving <= 1'b0;
      fast   <= 1'b0;
      state  <= IDLE;
      cnt    <= '0;
    end else begin
      tick_q <= tick;
      if (ev) begin
        dot_x <= x_next;
        dot_y <= y_next;
        if (!x_defl && !y_defl) begin
          state  <= IDLE;
          cnt    <= '0;
          moving <= 1'b0;
          fast   <= 1'b0;
        end else begin
          moving <= 1'b1;
          cnt    <= cnt_inc;
          if (cnt_inc == HOLD_C) begin
            state <= BOOST;
            fast  <= 1'b1;
          end else begin
            state <= SLOW;
            fast  <= 1'b0;
          end
        end
      end
    end
  end

endmodule
